// File: rtl/pair_mem_pkg.sv
// Shared definitions for the even/odd pair memory writer and its read-side counter.
// Both sides take the window bounds and address width from here so they agree on layout.
package pair_mem_pkg;

  localparam int PAIR_ADDR_W = 14;
  localparam int PAIR_START  = 6144;
  localparam int PAIR_END    = 6656;

  typedef enum logic [2:0] {
    IDLE,
    FILL_A,
    FILL_B,
    WRITE,
    DONE
  } pair_wr_state_t;

endpackage

// File: rtl/pair_addr_map.sv
// Maps a pair index onto its two word addresses.
// The even word goes to port A and the odd word goes to port B.
module pair_addr_map
  import pair_mem_pkg::*;
#(
  parameter int ADDR_W = PAIR_ADDR_W
) (
  input  logic [ADDR_W-2:0] pair_idx,
  output logic [ADDR_W-1:0] addr_a,
  output logic [ADDR_W-1:0] addr_b
);

  assign addr_a = {pair_idx, 1'b0};
  assign addr_b = {pair_idx, 1'b1};

endmodule

// File: rtl/pair_mem_writer.sv
// Packs a valid/ready sample stream into pairs and writes each pair in one cycle
// to a dual-port RAM, sweeping the pair window [START_PAIR, END_PAIR) once per start.
module pair_mem_writer
  import pair_mem_pkg::*;
#(
  parameter int ADDR_W     = PAIR_ADDR_W,
  parameter int DATA_W     = 8,
  parameter int START_PAIR = PAIR_START,
  parameter int END_PAIR   = PAIR_END
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              wr_en_a,
  output logic [ADDR_W-1:0] addr_a,
  output logic [DATA_W-1:0] data_a,
  output logic              wr_en_b,
  output logic [ADDR_W-1:0] addr_b,
  output logic [DATA_W-1:0] data_b,
  output logic              busy,
  output logic              done
);

  localparam int PAIR_W = ADDR_W - 1;
  localparam logic [PAIR_W-1:0] FIRST_IDX = PAIR_W'(START_PAIR);
  localparam logic [PAIR_W-1:0] LAST_IDX  = PAIR_W'(END_PAIR - 1);

  if (START_PAIR >= END_PAIR) begin : g_bad_window
    $error("pair_mem_writer: START_PAIR must be below END_PAIR");
  end
  if (END_PAIR > 2 ** (ADDR_W - 1)) begin : g_bad_end
    $error("pair_mem_writer: END_PAIR does not fit in the pair index width");
  end

  pair_wr_state_t    state;
  pair_wr_state_t    state_next;
  logic [PAIR_W-1:0] pair_idx;
  logic              accept;

  assign accept = in_valid && in_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = FILL_A;
      FILL_A:  if (accept) state_next = FILL_B;
      FILL_B:  if (accept) state_next = WRITE;
      WRITE:   state_next = (pair_idx == LAST_IDX) ? DONE : FILL_A;
      DONE:    if (start) state_next = FILL_A;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    wr_en_a  = 1'b0;
    wr_en_b  = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      FILL_A, FILL_B: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      WRITE: begin
        wr_en_a = 1'b1;
        wr_en_b = 1'b1;
        busy    = 1'b1;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // The pair index saturates on the last pair so the final address stays visible in DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pair_idx <= FIRST_IDX;
      data_a   <= '0;
      data_b   <= '0;
    end else begin
      case (state)
        IDLE, DONE: if (start) pair_idx <= FIRST_IDX;
        FILL_A:     if (accept) data_a <= in_data;
        FILL_B:     if (accept) data_b <= in_data;
        WRITE:      if (pair_idx != LAST_IDX) pair_idx <= pair_idx + 1'b1;
        default:    ;
      endcase
    end
  end

  pair_addr_map #(
    .ADDR_W(ADDR_W)
  ) u_addr_map (
    .pair_idx(pair_idx),
    .addr_a  (addr_a),
    .addr_b  (addr_b)
  );

endmodule

// File: tb/tb_pair_mem_writer.sv
// Self-checking bench for pair_mem_writer: a sample-count/write-count model checked every
// cycle, plus directed scenarios with literal expectations at key points.
module tb_pair_mem_writer;

  localparam int ADDR_W = 14;
  localparam int DATA_W = 8;
  localparam int START  = 6144;
  localparam int NPAIRS = 512;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_ready;
  logic              wr_en_a;
  logic [ADDR_W-1:0] addr_a;
  logic [DATA_W-1:0] data_a;
  logic              wr_en_b;
  logic [ADDR_W-1:0] addr_b;
  logic [DATA_W-1:0] data_b;
  logic              busy;
  logic              done;

  int compared = 0;
  int mismatched = 0;
  int dut_writes = 0;

  pair_mem_writer dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .in_valid(in_valid),
    .in_data (in_data),
    .in_ready(in_ready),
    .wr_en_a (wr_en_a),
    .addr_a  (addr_a),
    .data_a  (data_a),
    .wr_en_b (wr_en_b),
    .addr_b  (addr_b),
    .data_b  (data_b),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input longint actual, input longint expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Model: armed after a start, fill = samples held for the current pair, nwr = pairs written.
  logic armed = 1'b0;
  logic m_done = 1'b0;
  int   fill = 0;
  int   nwr = 0;
  logic [DATA_W-1:0] last_a = '0;
  logic [DATA_W-1:0] last_b = '0;
  logic exp_ready;
  int   exp_addr;

  assign exp_ready = armed && !m_done && (fill < 2);
  assign exp_addr  = 2 * (START + ((nwr < NPAIRS) ? nwr : NPAIRS - 1));

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      armed  <= 1'b0;
      m_done <= 1'b0;
      fill   <= 0;
      nwr    <= 0;
      last_a <= '0;
      last_b <= '0;
    end else begin
      if (fill == 2) begin
        fill <= 0;
        nwr  <= nwr + 1;
        if (nwr + 1 == NPAIRS) m_done <= 1'b1;
      end else if (in_valid && exp_ready) begin
        fill <= fill + 1;
        if (fill == 0) last_a <= in_data;
        else last_b <= in_data;
      end
      if (start && (!armed || m_done)) begin
        armed  <= 1'b1;
        m_done <= 1'b0;
        nwr    <= 0;
      end
    end
  end

  always @(negedge clk) begin
    check_output("wr_en_a", wr_en_a, fill == 2);
    check_output("wr_en_b", wr_en_b, fill == 2);
    check_output("in_ready", in_ready, exp_ready);
    check_output("busy", busy, armed && !m_done);
    check_output("done", done, m_done);
    check_output("addr_a", addr_a, exp_addr);
    check_output("addr_b", addr_b, exp_addr + 1);
    check_output("data_a", data_a, last_a);
    check_output("data_b", data_b, last_b);
    if (wr_en_a) dut_writes++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers one sample and returns just after the edge that accepted it.
  task automatic apply_stimulus(input logic [DATA_W-1:0] d);
    logic taken;
    taken = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int i = 0; i < 20 && !taken; i++) begin
      taken = in_ready;
      tick();
    end
    if (!taken) check_output("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  initial begin
    repeat (2) tick();
    check_output("rst_in_ready", in_ready, 0);
    check_output("rst_busy", busy, 0);
    check_output("rst_addr_a", addr_a, 12288);
    check_output("rst_data_a", data_a, 0);
    reset = 1'b0;
    tick();

    // start and in_valid together in IDLE: the sample waits for FILL_A
    start = 1'b1; in_valid = 1'b1; in_data = 8'h11;
    tick();
    start = 1'b0;
    tick();
    in_data = 8'h22;
    tick();
    in_valid = 1'b0;
    check_output("t1_wr_en_a", wr_en_a, 1);
    check_output("t1_addr_a", addr_a, 12288);
    check_output("t1_addr_b", addr_b, 12289);
    check_output("t1_data_a", data_a, 8'h11);
    check_output("t1_data_b", data_b, 8'h22);
    tick();
    check_output("t1_fill_a_ready", in_ready, 1);
    check_output("t1_next_addr", addr_a, 12290);

    // gap between the two samples, then valid held through WRITE
    in_valid = 1'b1; in_data = 8'h33;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    check_output("t2_gap_no_write", wr_en_a, 0);
    in_valid = 1'b1; in_data = 8'h44;
    tick();
    in_data = 8'h55;
    check_output("t2_write", wr_en_b, 1);
    check_output("t2_data_a", data_a, 8'h33);
    check_output("t2_data_b", data_b, 8'h44);
    tick();
    tick();
    check_output("t2_held_sample", data_a, 8'h55);
    in_data = 8'h66;
    tick();
    in_valid = 1'b0;
    check_output("t2_addr_a", addr_a, 12292);
    check_output("t2_data_b2", data_b, 8'h66);
    tick();

    // start in FILL_B and in WRITE is ignored
    in_valid = 1'b1; in_data = 8'h77;
    tick();
    in_valid = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    check_output("t3_fillb_busy", busy, 1);
    check_output("t3_fillb_addr", addr_a, 12294);
    in_valid = 1'b1; in_data = 8'h88;
    tick();
    in_valid = 1'b0; start = 1'b1;
    check_output("t3_write_data_a", data_a, 8'h77);
    check_output("t3_write_data_b", data_b, 8'h88);
    tick();
    start = 1'b0;
    check_output("t3_next_addr", addr_a, 12296);
    check_output("t3_ready", in_ready, 1);

    // reset after the first sample of pair 6200
    for (int k = 0; k < 104; k++) apply_stimulus(8'(k));
    apply_stimulus(8'hC3);
    check_output("t4_pair6200_addr", addr_a, 12400);
    check_output("t4_pair6200_data", data_a, 8'hC3);
    reset = 1'b1;
    #1;
    check_output("t4_rst_busy", busy, 0);
    check_output("t4_rst_addr", addr_a, 12288);
    check_output("t4_rst_data_a", data_a, 0);
    check_output("t4_rst_wr_en", wr_en_a, 0);
    repeat (2) tick();
    reset = 1'b0;
    tick();

    // full window, samples k mod 256
    dut_writes = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 2 * NPAIRS; k++) begin
      apply_stimulus(8'(k));
      if (k == 1) begin
        check_output("t5_first_addr", addr_a, 12288);
        check_output("t5_first_data_b", data_b, 1);
      end
    end
    check_output("t5_last_wr", wr_en_a, 1);
    check_output("t5_last_addr_a", addr_a, 13310);
    check_output("t5_last_addr_b", addr_b, 13311);
    check_output("t5_last_data_a", data_a, 254);
    check_output("t5_last_data_b", data_b, 255);
    tick();
    check_output("t5_done", done, 1);
    check_output("t5_done_ready", in_ready, 0);
    in_valid = 1'b1;
    repeat (4) tick();
    in_valid = 1'b0;
    check_output("t5_write_count", dut_writes, NPAIRS);
    check_output("t5_done_held", done, 1);

    // restart from DONE
    start = 1'b1;
    tick();
    start = 1'b0;
    check_output("t6_done_clear", done, 0);
    check_output("t6_busy", busy, 1);
    check_output("t6_addr", addr_a, 12288);
    apply_stimulus(8'hAA);
    apply_stimulus(8'hBB);
    check_output("t6_wr", wr_en_a, 1);
    check_output("t6_data_a", data_a, 8'hAA);
    check_output("t6_data_b", data_b, 8'hBB);
    tick();
    check_output("t6_next_addr", addr_a, 12290);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
